// File: rtl/fa_pkg.sv
// Shared types and default sizing for the flight-attendant call panel.
// The FSM state type lives here so the panel and any future monitor agree on encoding.
package fa_pkg;

    localparam int NUM_SEATS_DEF     = 8;
    localparam int SEAT_W_DEF        = 3;
    localparam int CLEAR_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESENT    = 2'd1,
        CANCEL     = 2'd2,
        WAIT_CLEAR = 2'd3
    } fa_state_t;

endpackage

// File: rtl/fa_attendant_panel_if.sv
// Console-side handshake of the attendant panel: one presented call, ack, status.
// master = attendant console, slave = panel.
interface fa_attendant_panel_if
    import fa_pkg::*;
#(
    parameter int SEAT_W = SEAT_W_DEF
);

    logic              ack;
    logic              req_valid;
    logic [SEAT_W-1:0] req_seat;
    logic [SEAT_W:0]   pending_count;
    logic              timeout_err;

    modport master (
        output ack,
        input  req_valid,
        input  req_seat,
        input  pending_count,
        input  timeout_err
    );

    modport slave (
        input  ack,
        output req_valid,
        output req_seat,
        output pending_count,
        output timeout_err
    );

endinterface

// File: rtl/fa_seat_fifo.sv
// Arrival-order queue of seat indices with a show-ahead head.
// A seat is never queued twice, so DEPTH entries are always enough.
module fa_seat_fifo
    import fa_pkg::*;
#(
    parameter int DEPTH  = NUM_SEATS_DEF,
    parameter int SEAT_W = SEAT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [SEAT_W-1:0] push_seat,
    input  logic              pop,
    output logic [SEAT_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic [SEAT_W:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SEAT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [SEAT_W:0]   count_reg;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_seat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign full  = (count_reg == (SEAT_W + 1)'(DEPTH));
    assign count = count_reg;

endmodule

// File: rtl/fa_attendant_panel.sv
// Attendant end of the call interface: detects seat-light rises, queues them in
// arrival order, presents one at a time and pulses cancel on acknowledge.
module fa_attendant_panel
    import fa_pkg::*;
#(
    parameter int NUM_SEATS     = NUM_SEATS_DEF,
    parameter int SEAT_W        = SEAT_W_DEF,
    parameter int CLEAR_TIMEOUT = CLEAR_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SEATS-1:0] light_state,
    output logic [NUM_SEATS-1:0] cancel_out,
    fa_attendant_panel_if.slave  console
);

    localparam int CNT_W = $clog2(CLEAR_TIMEOUT + 1);

    fa_state_t             state_reg, state_next;
    logic [NUM_SEATS-1:0]  light_q_reg;
    logic [NUM_SEATS-1:0]  pend_reg, pend_next;
    logic [NUM_SEATS-1:0]  queued_reg, queued_next;
    logic [NUM_SEATS-1:0]  cancel_reg, cancel_next;
    logic [SEAT_W-1:0]     seat_reg, seat_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  timeout_err_reg;
    logic                  timeout_set;

    logic [NUM_SEATS-1:0]  rise;
    logic [NUM_SEATS-1:0]  cand;
    logic [NUM_SEATS-1:0]  push_mask;
    logic [NUM_SEATS-1:0]  clr_mask;
    logic                  push;
    logic [SEAT_W-1:0]     push_seat;
    logic                  pop;
    logic [SEAT_W-1:0]     fifo_head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [SEAT_W:0]       fifo_count;
    logic                  head_lit;
    logic                  seat_lit;

    assign rise = light_state & ~light_q_reg;
    assign cand = pend_reg & ~queued_reg;

    // Lowest index wins, so simultaneous calls enqueue in ascending seat order.
    always_comb begin
        push      = 1'b0;
        push_seat = '0;
        for (int i = NUM_SEATS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                push      = 1'b1;
                push_seat = SEAT_W'(i);
            end
        end
    end

    assign push_mask = push ? (NUM_SEATS'(1) << push_seat) : '0;
    assign head_lit  = light_state[fifo_head];
    assign seat_lit  = light_state[seat_reg];

    fa_seat_fifo #(
        .DEPTH  (NUM_SEATS),
        .SEAT_W (SEAT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_seat (push_seat),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_comb begin
        state_next  = state_reg;
        seat_next   = seat_reg;
        cnt_next    = cnt_reg;
        cancel_next = '0;
        clr_mask    = '0;
        pop         = 1'b0;
        timeout_set = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head_lit) begin
                        state_next = PRESENT;
                    end else begin
                        // Passenger already cancelled: drop silently, no pulse.
                        pop      = 1'b1;
                        clr_mask = NUM_SEATS'(1) << fifo_head;
                    end
                end
            end
            PRESENT: begin
                if (console.ack) begin
                    pop         = 1'b1;
                    seat_next   = fifo_head;
                    cancel_next = NUM_SEATS'(1) << fifo_head;
                    state_next  = CANCEL;
                end else if (!head_lit) begin
                    pop        = 1'b1;
                    clr_mask   = NUM_SEATS'(1) << fifo_head;
                    state_next = IDLE;
                end
            end
            CANCEL: begin
                cnt_next   = CNT_W'(CLEAR_TIMEOUT);
                state_next = WAIT_CLEAR;
            end
            WAIT_CLEAR: begin
                if (!seat_lit) begin
                    clr_mask   = NUM_SEATS'(1) << seat_reg;
                    state_next = IDLE;
                end else if (cnt_reg <= CNT_W'(1)) begin
                    timeout_set = 1'b1;
                    clr_mask    = NUM_SEATS'(1) << seat_reg;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A rise on an already-queued seat is remembered in pend until queued clears.
    assign pend_next   = (pend_reg & ~push_mask) | rise;
    assign queued_next = (queued_reg & ~clr_mask) | push_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            light_q_reg     <= '0;
            pend_reg        <= '0;
            queued_reg      <= '0;
            cancel_reg      <= '0;
            seat_reg        <= '0;
            cnt_reg         <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            light_q_reg     <= light_state;
            pend_reg        <= pend_next;
            queued_reg      <= queued_next;
            cancel_reg      <= cancel_next;
            seat_reg        <= seat_next;
            cnt_reg         <= cnt_next;
            timeout_err_reg <= timeout_err_reg | timeout_set;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));

    assign cancel_out            = cancel_reg;
    assign console.req_valid     = (state_reg == PRESENT);
    assign console.req_seat      = (state_reg == PRESENT) ? fifo_head : '0;
    assign console.pending_count = fifo_count;
    assign console.timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_fa_attendant_panel.sv
// Bench for fa_attendant_panel: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_fa_attendant_panel;

    localparam int NS = 8;
    localparam int SW = 3;
    localparam int CT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [NS-1:0] light;
    logic [NS-1:0] cancel_out;

    fa_attendant_panel_if #(.SEAT_W(SW)) console ();

    fa_attendant_panel #(
        .NUM_SEATS     (NS),
        .SEAT_W        (SW),
        .CLEAR_TIMEOUT (CT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .light_state (light),
        .cancel_out  (cancel_out),
        .console     (console)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wait_valid(input string name, input int budget, output int edges);
        edges = 0;
        while (console.req_valid !== 1'b1 && edges < budget) begin
            @(negedge clk);
            edges++;
        end
        if (console.req_valid !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s req_valid never rose within %0d cycles", name, budget);
        end
    endtask

    typedef struct {
        logic [NS-1:0] light;
        logic          ack;
        logic          valid;
        logic [SW-1:0] seat;
        logic [NS-1:0] cancel;
        logic [SW:0]   count;
    } vec_t;

    vec_t vecs[$];

    // ---------------- reference model ----------------
    bit [NS-1:0] m_prev, m_pend, m_queued, m_cancel;
    int          m_q[$];
    bit          m_presenting;
    int          m_serving;
    int          m_serve_start;
    int          m_step;
    bit          m_terr;

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_queued = '0; m_cancel = '0;
        m_q.delete();
        m_presenting = 1'b0; m_serving = -1; m_serve_start = 0; m_step = 0; m_terr = 1'b0;
    endtask

    // One clock of the call-handling rules, expressed as a queue plus a served-seat timer.
    task automatic model_step(input bit [NS-1:0] lt, input bit a);
        bit [NS-1:0] rise, freed, cancel_now;
        int          pick;
        bit          popped;
        rise = lt & ~m_prev; freed = '0; cancel_now = '0; pick = -1; popped = 1'b0;
        m_step++;
        for (int i = 0; i < NS; i++) if (pick < 0 && m_pend[i] && !m_queued[i]) pick = i;
        if (m_serving >= 0) begin
            if (m_step > m_serve_start) begin
                if (!lt[m_serving]) begin
                    freed[m_serving] = 1'b1; m_serving = -1;
                end else if (m_step - m_serve_start >= CT) begin
                    m_terr = 1'b1; freed[m_serving] = 1'b1; m_serving = -1;
                end
            end
        end else if (m_presenting) begin
            if (a) begin
                popped = 1'b1; m_serving = m_q[0]; m_serve_start = m_step + 1;
                cancel_now[m_q[0]] = 1'b1; m_presenting = 1'b0;
            end else if (!lt[m_q[0]]) begin
                popped = 1'b1; freed[m_q[0]] = 1'b1; m_presenting = 1'b0;
            end
        end else if (m_q.size() > 0) begin
            if (lt[m_q[0]]) m_presenting = 1'b1;
            else begin popped = 1'b1; freed[m_q[0]] = 1'b1; end
        end
        if (popped) void'(m_q.pop_front());
        m_queued &= ~freed;
        if (pick >= 0) begin
            m_q.push_back(pick); m_queued[pick] = 1'b1; m_pend[pick] = 1'b0;
        end
        m_pend  |= rise;
        m_cancel = cancel_now;
        m_prev   = lt;
    endtask

    task automatic add(input logic [NS-1:0] l, input logic a, input logic v,
                       input logic [SW-1:0] s, input logic [NS-1:0] c, input logic [SW:0] n);
        vec_t r;
        r.light = l; r.ack = a; r.valid = v; r.seat = s; r.cancel = c; r.count = n;
        vecs.push_back(r);
    endtask

    initial begin
        int edges;
        int exp_seat;

        // Single call on seat 3, ack one cycle after presentation, then ack while idle.
        add(8'h08,0,0,0,8'h00,0); add(8'h08,0,0,0,8'h00,1); add(8'h08,0,1,3,8'h00,1);
        add(8'h08,0,1,3,8'h00,1); add(8'h08,1,0,0,8'h08,0); add(8'h08,0,0,0,8'h00,0);
        add(8'h00,0,0,0,8'h00,0); add(8'h00,1,0,0,8'h00,0);
        // Seats 5 and 2 together: 2 first, then 5.
        add(8'h24,0,0,0,8'h00,0); add(8'h24,0,0,0,8'h00,1); add(8'h24,0,1,2,8'h00,2);
        add(8'h24,1,0,0,8'h04,1); add(8'h20,0,0,0,8'h00,1); add(8'h20,0,0,0,8'h00,1);
        add(8'h20,0,1,5,8'h00,1); add(8'h20,1,0,0,8'h20,0); add(8'h00,0,0,0,8'h00,0);
        add(8'h00,0,0,0,8'h00,0);
        // Seat 6 self-cancels, then calls again and is served.
        add(8'h40,0,0,0,8'h00,0); add(8'h40,0,0,0,8'h00,1); add(8'h40,0,1,6,8'h00,1);
        add(8'h00,0,0,0,8'h00,0); add(8'h00,0,0,0,8'h00,0); add(8'h40,0,0,0,8'h00,0);
        add(8'h40,0,0,0,8'h00,1); add(8'h40,0,1,6,8'h00,1); add(8'h40,1,0,0,8'h40,0);
        add(8'h00,0,0,0,8'h00,0); add(8'h00,0,0,0,8'h00,0);
        // Seat 0: ack and light drop in the same cycle, then a fresh call.
        add(8'h01,0,0,0,8'h00,0); add(8'h01,0,0,0,8'h00,1); add(8'h01,0,1,0,8'h00,1);
        add(8'h00,1,0,0,8'h01,0); add(8'h00,0,0,0,8'h00,0); add(8'h00,0,0,0,8'h00,0);
        add(8'h01,0,0,0,8'h00,0); add(8'h01,0,0,0,8'h00,1); add(8'h01,0,1,0,8'h00,1);
        add(8'h00,0,0,0,8'h00,0);

        reset = 1'b0; light = '0; console.ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", console.req_valid, 0);
        check("rst_seat", console.req_seat, 0);
        check("rst_cancel", cancel_out, 0);
        check("rst_count", console.pending_count, 0);
        check("rst_terr", console.timeout_err, 0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            light = vecs[i].light; console.ack = vecs[i].ack;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), console.req_valid, vecs[i].valid);
            check($sformatf("vec%0d_seat", i), console.req_seat, vecs[i].seat);
            check($sformatf("vec%0d_cancel", i), cancel_out, vecs[i].cancel);
            check($sformatf("vec%0d_count", i), console.pending_count, vecs[i].count);
            $display("vec %0d light=%02h ack=%0d valid=%0d seat=%0d cancel=%02h count=%0d",
                     i, light, console.ack, console.req_valid, console.req_seat, cancel_out,
                     console.pending_count);
        end
        console.ack = 1'b0;
        check("table_terr", console.timeout_err, 0);

        // Timeout on seat 1: light held after ack.
        light = 8'h02;
        wait_valid("to_present", 10, edges);
        check("to_latency", edges, 3);
        check("to_seat", console.req_seat, 1);
        console.ack = 1'b1;
        @(negedge clk);
        console.ack = 1'b0;
        check("to_cancel", cancel_out, 8'h02);
        @(negedge clk);
        check("to_cancel_once", cancel_out, 8'h00);
        repeat (CT - 1) @(negedge clk);
        check("to_terr_early", console.timeout_err, 0);
        @(negedge clk);
        check("to_terr_set", console.timeout_err, 1);
        repeat (5) @(negedge clk);
        check("to_no_repres", console.req_valid, 0);
        check("to_count", console.pending_count, 0);
        light = 8'h00;
        repeat (2) @(negedge clk);
        light = 8'h02;
        wait_valid("to_fresh", 10, edges);
        check("to_fresh_seat", console.req_seat, 1);
        check("to_terr_sticky", console.timeout_err, 1);
        light = 8'h00;
        repeat (3) @(negedge clk);
        $display("timeout sequence done terr=%0d", console.timeout_err);

        // Reset while cancelling seat 1 with seats 1,2,4,7 queued.
        light = 8'h96;
        wait_valid("rc_present", 12, edges);
        check("rc_seat", console.req_seat, 1);
        repeat (2) @(negedge clk);
        check("rc_count4", console.pending_count, 4);
        console.ack = 1'b1;
        @(negedge clk);
        console.ack = 1'b0;
        check("rc_cancel", cancel_out, 8'h02);
        check("rc_count3", console.pending_count, 3);
        reset = 1'b0;
        light = 8'h00;
        #1;
        check("rc_rst_cancel", cancel_out, 0);
        check("rc_rst_valid", console.req_valid, 0);
        check("rc_rst_count", console.pending_count, 0);
        check("rc_rst_terr", console.timeout_err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("rc_quiet_valid", console.req_valid, 0);
        check("rc_quiet_count", console.pending_count, 0);
        check("rc_quiet_cancel", cancel_out, 0);
        light = 8'h10;
        wait_valid("rc_redetect", 10, edges);
        check("rc_redetect_lat", edges, 3);
        check("rc_redetect_seat", console.req_seat, 4);
        light = 8'h00;
        repeat (3) @(negedge clk);
        $display("reset sequence done");

        // Randomized traffic against the reference model.
        reset = 1'b0; light = '0; console.ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_seat = m_presenting ? m_q[0] : 0;
            check("rnd_valid", console.req_valid, m_presenting);
            check("rnd_seat", console.req_seat, exp_seat);
            check("rnd_cancel", cancel_out, m_cancel);
            check("rnd_count", console.pending_count, m_q.size());
            check("rnd_terr", console.timeout_err, m_terr);
            for (int i = 0; i < NS; i++) begin
                if (light[i]) begin
                    if (m_cancel[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 11) == 0))
                        light[i] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    light[i] = 1'b1;
                end
            end
            console.ack = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            model_step(light, console.ack);
            if (m_cancel != '0)
                $display("txn cycle=%0d served seat=%0d queued=%0d", cyc, m_serving, m_q.size());
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fa_attendant_panel.md
Name: fa_attendant_panel

Overview:
- Attendant-side end of the flight-attendant call interface. Monitors the light_state outputs of NUM_SEATS seat call units and queues calls in arrival order.
- Presents one call at a time to the attendant console through a valid/ack handshake.
- On acknowledge, drives a one-cycle pulse on that seat's cancel_button input, then waits for the seat light to clear.

Parameters:
NUM_SEATS, 8, number of seat call units monitored
SEAT_W, 3, seat index width (>= clog2(NUM_SEATS))
CLEAR_TIMEOUT, 15, cycles to wait for a seat light to drop after cancel before giving up

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
light_state  input  NUM_SEATS  per-seat call light from seat units, same clock domain
ack  input  1  attendant accepts presented call; honoured only while req_valid=1
req_valid  output  1  a live call is presented on req_seat
req_seat  output  SEAT_W  index of presented seat
cancel_out  output  NUM_SEATS  one-hot, one-cycle cancel pulse to the seat's cancel_button
pending_count  output  SEAT_W+1  number of seats queued, including the presented seat
timeout_err  output  1  sticky; set when a seat light fails to clear within CLEAR_TIMEOUT

Behaviour:
- Reset (reset=0, async): light_q=0, queued=0, FIFO empty, FSM=IDLE; req_valid=0, req_seat=0, cancel_out=0, pending_count=0, timeout_err=0. Reset mid-operation drops all calls and aborts any cancel pulse.
- Edge detect: light_q <= light_state every cycle; rise = light_state & ~light_q.
- Pending: pend[i] is set on rise[i].
- Enqueue: each cycle, the lowest index i with pend[i] & ~queued[i] is pushed to the FIFO. That sets queued[i] and clears pend[i]. At most one push per cycle, so simultaneous rises enqueue in ascending index order on consecutive cycles.
- A seat appears in the queue at most once, so a FIFO depth of NUM_SEATS never overflows. Full and push together cannot occur; an assertion checks this.
- FSM states: IDLE, PRESENT, CANCEL, WAIT_CLEAR.
  - IDLE: if the FIFO is non-empty and light_state[head]=1, go to PRESENT. If the FIFO is non-empty and light_state[head]=0 (stale call, passenger self-cancelled), pop the head, clear queued[head], and stay in IDLE. No cancel pulse is issued.
  - PRESENT: req_valid=1, req_seat=head.
    - ack=1: pop, latch the seat, go to CANCEL.
    - Light drops before ack: deassert req_valid, pop, go to IDLE.
    - ack and light drop in the same cycle: the ack wins.
  - CANCEL: one cycle; cancel_out[seat]=1, req_valid=0, load the timeout counter. Go to WAIT_CLEAR.
  - WAIT_CLEAR: when light_state[seat]=0, clear queued[seat] and go to IDLE. When the counter expires, set timeout_err, clear queued[seat], and go to IDLE.
  - A new rise on a seat still in queued=1 sets pend only. It is enqueued after queued clears.
- Latency: with an empty queue and the FSM in IDLE, light_state[i] rising before edge k gives pend at k, FIFO push at k+1, PRESENT at k+2. req_valid is therefore high after edge k+2 (3 edges).
- cancel_out is a registered output and is never asserted for more than one cycle per ack.
- ack is ignored while req_valid=0.
- pending_count increments on push and decrements on pop. A push and a pop in the same cycle leave it unchanged.
- timeout_err is cleared only by reset.

Decomposition:
- Package fa_pkg: FSM state enum (IDLE, PRESENT, CANCEL, WAIT_CLEAR), default NUM_SEATS/SEAT_W constants, CLEAR_TIMEOUT default.
- Sub-module fa_seat_fifo: synchronous FIFO of SEAT_W-bit seat indices, depth NUM_SEATS, with push, pop, head, empty, full and count outputs.
- Edge detect, pending/queued vectors, the priority pick and the FSM live in the top module.

Test Plan:
- Single call: seat 3 rises, ack one cycle after req_valid -> req_valid on 3rd edge with req_seat=3; cancel_out=8'b0000_1000 for exactly 1 cycle; when seat light drops, pending_count returns 0.
- Simultaneous rises on seats 5 and 2 -> presented in order 2 then 5. pending_count reads 2, then 1 after the first ack, then 0.
- Passenger self-cancel: seat 6 rises, then falls before ack -> req_valid drops, no cancel_out pulse, FIFO empty; rising again re-queues seat 6.
- Timeout: ack seat 1 and hold light_state[1]=1 -> timeout_err=1 after CLEAR_TIMEOUT cycles in WAIT_CLEAR; FSM returns to IDLE and re-presents seat 1 only after a fresh rise.
- Reset mid-CANCEL with 4 seats queued -> all outputs 0 immediately; no residual cancel pulse; calls are re-detected only on new rising edges.
- Ack and light drop in the same cycle on seat 0 -> ack honoured, cancel_out[0] pulses once, FSM goes via WAIT_CLEAR (light already 0) to IDLE the next cycle.
